vmem_lane_seq: RTL
==================

# vmem_lane_seq

Vector load/store memory sequencer. It sits between the vector datapath and a single 32-bit data-memory port. It accepts one 4-lane vector memory operation: per-lane addresses from the vector ALU outputs, per-lane mask bits, and 128-bit store data from vs3. It issues the active lanes to memory one word at a time and, for loads, assembles the 128-bit XDMEM writeback word.

## Interface

Parameters:
- LANES, 4, number of 32-bit lanes; the design is fixed at 4.
- XLEN, 32, lane and memory word width.
- VLEN, 128, vector register width; must equal LANES*XLEN.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-high reset. The port name follows the codebase; the signal is asserted at 1.
- start  in  1  request a new operation; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; captured with start.
- lane_addr  in  LANES*XLEN  lane i byte address in bits [32i+31:32i] (VALUOut0..3).
- lane_mask  in  LANES  vm0..vm3; 1 = lane active.
- st_data  in  VLEN  vs3 store data; lane i in bits [32i+31:32i].
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  XLEN  word address of the current lane.
- mem_wdata  out  XLEN  store data of the current lane.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- busy  out  1  operation in progress; the datapath stalls while this is high.
- done  out  1  one-cycle completion pulse.
- xdmem  out  VLEN  assembled load data; held until the next load completes.

## Operation

- FSM states are IDLE, REQ, WAIT and DONE.
- **IDLE:**
  - When start=1, capture is_store, lane_addr, lane_mask and st_data.
  - Set the lane pointer to the lowest active lane.
  - If lane_mask==0, go to DONE; otherwise go to REQ.
- **REQ:**
  - mem_req=1 and mem_we=is_store.
  - mem_addr and mem_wdata come from the current lane's captured fields.
  - On mem_gnt, a store advances to the next higher active lane, or to DONE when none remains.
  - On mem_gnt, a load goes to WAIT.
  - Without mem_gnt, hold all request outputs stable.
- **WAIT:**
  - mem_req=0.
  - On mem_rvalid, write mem_rdata into lane slot [32i+31:32i] of the load buffer.
  - Then advance to the next active lane (REQ) or to DONE.
- **DONE:**
  - done=1 for exactly one cycle.
  - A load copies the buffer to xdmem in this cycle; a store leaves xdmem unchanged.
  - Return to IDLE.
- Masked lanes of a load read as 0 in xdmem. Masked lanes are never issued to memory.
- At most one request is outstanding. mem_rvalid outside WAIT is ignored.
- start is ignored while busy. Captured operands are frozen for the whole operation.
- Lanes are always issued in ascending order, 0 to 3.
- mem_addr and mem_wdata drive 0 whenever mem_req=0.

## Timing

- Reset values:
  - State is IDLE.
  - busy, done, mem_req and mem_we are 0.
  - mem_addr, mem_wdata, xdmem and the load buffer are 0.
- busy=1 in every non-IDLE state, including DONE. It rises the cycle after start is accepted.
- The memory contract: mem_rvalid arrives no earlier than the cycle after mem_gnt.
- Latencies with a zero-wait memory (mem_gnt tied high, rvalid one cycle after gnt), where N is the number of active lanes:
  - Store: N REQ cycles; done falls in cycle N+1 after start.
  - Load: 2N cycles; done falls in cycle 2N+1 after start. All 4 lanes active gives done at cycle 9.
  - All lanes masked: done in cycle 1.
- Reset asserted mid-operation drops mem_req immediately (asynchronously). The operation is abandoned with no done pulse, and xdmem is cleared.
- start asserted in the same cycle as done is ignored. A new operation can start the cycle after DONE.

## Structure

- Shared package vmem_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - the LANES and XLEN constants;
  - the lane-slice index helper constants.
- One sub-module, vmem_lane_pick:
  - combinational priority finder;
  - inputs: mask and current lane;
  - outputs: next active lane index above the current one, plus a none-left flag.
  - It is used both for the first-lane selection and for lane advance.

## Test plan

- Store, mask 4'b1111, addresses 0x100/0x104/0x108/0x10C, st_data 0xDDDD_CCCC_BBBB_AAAA_..., gnt tied 1 -> four writes in lane order with the matching wdata; done at cycle 5; xdmem unchanged.
- Load, mask 4'b1111, memory returns 0x11, 0x22, 0x33, 0x44 -> xdmem = {0x44,0x33,0x22,0x11} at done (cycle 9); busy high in cycles 1–9.
- Load, mask 4'b1010 -> only lanes 1 and 3 issued; xdmem lanes 0 and 2 are 0.
- Mask 4'b0000 -> no mem_req; done at cycle 1.
- Backpressure: gnt held low for 3 cycles on lane 2 -> mem_req, mem_addr and mem_wdata stable throughout; start pulses during busy ignored.
- Reset asserted while in WAIT on lane 1 -> mem_req and busy immediately 0; no done; xdmem 0; the next start runs normally.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared definitions for the vector memory lane sequencer.
package vmem_pkg;

  localparam int LANES  = 4;
  localparam int XLEN   = 32;
  localparam int VLEN   = LANES * XLEN;
  localparam int LANE_W = 2;

  // Sequencer states, kept as plain constants for legacy tool compatibility
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Bit offset of lane slot [32i+31:32i] inside a packed vector word
  function automatic int lane_lsb(input logic [LANE_W-1:0] lane);
    return int'(lane) * XLEN;
  endfunction

endpackage

// File: rtl/vmem_lane_pick.sv
// Priority finder: lowest active lane above the current one (or at it
// when incl=1), plus a flag telling that no such lane exists.
module vmem_lane_pick
  import vmem_pkg::*;
(
  input  logic [LANES-1:0]  mask,
  input  logic [LANE_W-1:0] cur,
  input  logic              incl,
  output logic [LANE_W-1:0] pick_lane,
  output logic              none_left
);

  // Scan from the top down so the lowest qualifying lane wins
  always_comb begin
    pick_lane = cur;
    none_left = 1'b1;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        pick_lane = LANE_W'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vmem_lane_seq.sv
// Vector load/store sequencer: issues the active lanes of one 4-lane
// operation to a single 32-bit memory port, in ascending lane order, and
// assembles the 128-bit load result. rst_n is asserted high.
module vmem_lane_seq
  import vmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [VLEN-1:0]  lane_addr,
  input  logic [LANES-1:0] lane_mask,
  input  logic [VLEN-1:0]  st_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [VLEN-1:0]  xdmem
);

  state_t            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              store_q, store_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [VLEN-1:0]   addr_q, addr_d;
  logic [VLEN-1:0]   wdata_q, wdata_d;
  logic [VLEN-1:0]   buf_q, buf_d;
  logic [VLEN-1:0]   xdmem_q, xdmem_d;

  logic [LANE_W-1:0] first_lane, next_lane;
  logic              first_none, next_none;
  logic              req;
  logic              load_op;

  // First active lane of the incoming mask (lane 0 itself qualifies)
  vmem_lane_pick u_first (
    .mask      (lane_mask),
    .cur       ({LANE_W{1'b0}}),
    .incl      (1'b1),
    .pick_lane (first_lane),
    .none_left (first_none)
  );

  // Next active lane strictly above the one in flight
  vmem_lane_pick u_next (
    .mask      (mask_q),
    .cur       (lane_q),
    .incl      (1'b0),
    .pick_lane (next_lane),
    .none_left (next_none)
  );

  // Next-state logic: capture, lane advance, load buffer fill
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    store_d = store_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    xdmem_d = xdmem_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          store_d = is_store;
          mask_d  = lane_mask;
          addr_d  = lane_addr;
          wdata_d = st_data;
          buf_d   = '0;            // masked lanes of a load read as zero
          lane_d  = first_lane;
          state_d = first_none ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (!store_q) begin
            state_d = ST_WAIT;
          end else if (next_none) begin
            state_d = ST_DONE;
          end else begin
            lane_d = next_lane;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          buf_d[lane_lsb(lane_q) +: XLEN] = mem_rdata;
          if (next_none) begin
            state_d = ST_DONE;
          end else begin
            lane_d  = next_lane;
            state_d = ST_REQ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Publish the load result on entry to DONE so it is visible with the
    // done pulse; buf_d already holds the final lane's data here.
    load_op = (state_q == ST_IDLE) ? !is_store : !store_q;
    if ((state_d == ST_DONE) && (state_q != ST_DONE) && load_op) begin
      xdmem_d = buf_d;
    end
  end

  // State and operand registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      store_q <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      xdmem_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      store_q <= store_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      xdmem_q <= xdmem_d;
    end
  end

  // Outputs decode straight from the state flop, so reset drops them at once.
  // The lane byte address is presented as-is: it is the address of the word.
  assign req       = (state_q == ST_REQ);
  assign mem_req   = req;
  assign mem_we    = req & store_q;
  assign mem_addr  = req ? addr_q[lane_lsb(lane_q) +: XLEN]  : '0;
  assign mem_wdata = req ? wdata_q[lane_lsb(lane_q) +: XLEN] : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign xdmem     = xdmem_q;

endmodule
